// File: rtl/sliding_window_buffer_pkg.sv
// Shared sizing and indexing helpers for the sliding-window buffer and its bench.
package sliding_window_buffer_pkg;

  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int hop_w(input int hop);
    return (hop <= 2) ? 1 : $clog2(hop);
  endfunction

  // Flat tap index of tap i of channel c; multiply by the word width for a bit offset.
  function automatic int tap_idx(input int c, input int i, input int depth);
    return c * depth + i;
  endfunction

endpackage

// File: rtl/sliding_window_buffer_lane.sv
// One channel of the window: a DEPTH-deep tap chain that shifts on accept.
module window_lane #(
  parameter int WORD_WIDTH = 4,
  parameter int DEPTH      = 21
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          shift,
  input  logic [WORD_WIDTH-1:0]         din,
  output logic [DEPTH*WORD_WIDTH-1:0]   taps
);

  logic [WORD_WIDTH-1:0] tap_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tap_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) tap_q[i] <= '0;
    end else if (shift) begin
      tap_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) tap_q[i] <= tap_q[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_tap
    assign taps[i*WORD_WIDTH +: WORD_WIDTH] = tap_q[i];
  end

endmodule

// File: rtl/sliding_window_buffer.sv
// Multi-channel sliding-window buffer: first window after DEPTH accepts, then one every HOP accepts.
module sliding_window_buffer
  import sliding_window_buffer_pkg::*;
#(
  parameter int WORD_WIDTH = 4,
  parameter int DEPTH      = 21,
  parameter int CHANNELS   = 1,
  parameter int HOP        = 1,
  localparam int FILL_W    = fill_w(DEPTH),
  localparam int HOP_W     = hop_w(HOP)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   clear,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [CHANNELS*WORD_WIDTH-1:0]         din,
  output logic                                   win_valid,
  input  logic                                   win_ready,
  output logic [CHANNELS*DEPTH*WORD_WIDTH-1:0]   win_data,
  output logic [CHANNELS*WORD_WIDTH-1:0]         dout,
  output logic [FILL_W-1:0]                      fill
);

  logic [FILL_W-1:0] fill_q;
  logic [HOP_W-1:0]  hop_cnt;
  logic              win_valid_q;
  logic              accept;
  logic              full;
  logic              fire;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high.
  // A presented window is only replaced once it is taken, so input stalls while
  // win_valid is high and win_ready is low; clear also blocks input for its cycle.
  assign in_ready = !clear && (!win_valid_q || win_ready);
  assign accept   = in_valid && in_ready;
  assign full     = (fill_q == FILL_W'(DEPTH));
  assign fire     = accept && ((fill_q == FILL_W'(DEPTH - 1)) ||
                               (full && (hop_cnt == HOP_W'(HOP - 1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q      <= '0;
      hop_cnt     <= '0;
      win_valid_q <= 1'b0;
    end else if (clear) begin
      fill_q      <= '0;
      hop_cnt     <= '0;
      win_valid_q <= 1'b0;
    end else begin
      if (accept && !full) fill_q <= fill_q + FILL_W'(1);

      if (fire)                hop_cnt <= '0;
      else if (accept && full) hop_cnt <= hop_cnt + HOP_W'(1);

      // A fire coinciding with the handshake keeps the flag set for the next window.
      if (fire)           win_valid_q <= 1'b1;
      else if (win_ready) win_valid_q <= 1'b0;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    window_lane #(
      .WORD_WIDTH (WORD_WIDTH),
      .DEPTH      (DEPTH)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .shift (accept),
      .din   (din[c*WORD_WIDTH +: WORD_WIDTH]),
      .taps  (win_data[c*DEPTH*WORD_WIDTH +: DEPTH*WORD_WIDTH])
    );

    assign dout[c*WORD_WIDTH +: WORD_WIDTH] =
      win_data[tap_idx(c, DEPTH - 1, DEPTH)*WORD_WIDTH +: WORD_WIDTH];
  end

  assign win_valid = win_valid_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Bench for sliding_window_buffer: HOP=2 instance against a sample-history model, plus a HOP=1 instance.
module tb_sliding_window_buffer;
  import sliding_window_buffer_pkg::*;

  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int CH    = 2;
  localparam int HOP   = 2;
  localparam int WD    = CH * DEPTH * W;
  localparam int FW    = fill_w(DEPTH);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            clear, in_valid, in_ready, win_valid, win_ready;
  logic [CH*W-1:0] din, dout;
  logic [WD-1:0]   win_data;
  logic [FW-1:0]   fill;

  logic            clear1, in_valid1, in_ready1, win_valid1, win_ready1;
  logic [CH*W-1:0] din1, dout1;
  logic [WD-1:0]   win_data1;
  logic [FW-1:0]   fill1;

  sliding_window_buffer #(.WORD_WIDTH(W), .DEPTH(DEPTH), .CHANNELS(CH), .HOP(HOP)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .dout(dout), .fill(fill)
  );

  sliding_window_buffer #(.WORD_WIDTH(W), .DEPTH(DEPTH), .CHANNELS(CH), .HOP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(in_valid1), .in_ready(in_ready1),
    .din(din1), .win_valid(win_valid1), .win_ready(win_ready1), .win_data(win_data1),
    .dout(dout1), .fill(fill1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: last DEPTH accepted samples per channel, accept count, pending window
  logic [W-1:0] m_taps [CH][DEPTH];
  int           m_count;
  bit           m_wv;
  logic         obs_ready;

  task automatic model_reset();
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < DEPTH; i++) m_taps[c][i] = '0;
    m_count = 0;
    m_wv    = 1'b0;
  endtask

  function automatic logic [WD-1:0] exp_win();
    logic [WD-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < DEPTH; i++) v[tap_idx(c, i, DEPTH)*W +: W] = m_taps[c][i];
    return v;
  endfunction

  function automatic logic [CH*W-1:0] exp_dout();
    logic [CH*W-1:0] v;
    for (int c = 0; c < CH; c++) v[c*W +: W] = m_taps[c][DEPTH-1];
    return v;
  endfunction

  function automatic logic [FW-1:0] exp_fill();
    return FW'((m_count > DEPTH) ? DEPTH : m_count);
  endfunction

  // driver: called at a negedge, drives one cycle, updates the model, returns at the next negedge
  task automatic step(input bit v, input logic [CH*W-1:0] d, input bit r, input bit cl);
    bit acc, fire;
    in_valid  = v;
    din       = d;
    win_ready = r;
    clear     = cl;
    acc = v && !cl && (!m_wv || r);
    #1 obs_ready = in_ready;
    @(posedge clk);
    if (cl) begin
      model_reset();
    end else begin
      fire = 1'b0;
      if (acc) begin
        for (int c = 0; c < CH; c++) begin
          for (int i = DEPTH - 1; i > 0; i--) m_taps[c][i] = m_taps[c][i-1];
          m_taps[c][0] = d[c*W +: W];
        end
        m_count++;
        fire = (m_count == DEPTH) || (m_count > DEPTH && ((m_count - DEPTH) % HOP) == 0);
      end
      if (fire)           m_wv = 1'b1;
      else if (m_wv && r) m_wv = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_checks++; if (win_valid !== 1'b0) $display("FAIL reset_win_valid got=%b exp=0", win_valid); else n_pass++;
    n_checks++; if (fill !== '0) $display("FAIL reset_fill got=%0d exp=0", fill); else n_pass++;
    n_checks++; if (win_data !== '0) $display("FAIL reset_win_data got=%h exp=0", win_data); else n_pass++;
    n_checks++; if (dout !== '0) $display("FAIL reset_dout got=%h exp=0", dout); else n_pass++;
    n_checks++; if (win_valid1 !== 1'b0 || in_ready1 !== 1'b1)
      $display("FAIL reset_hop1 got wv=%b rdy=%b exp wv=0 rdy=1", win_valid1, in_ready1); else n_pass++;
  endtask

  task automatic test_first_window();
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, {4'(8 + k), 4'(k)}, 1'b1, 1'b0);
      n_checks++; if (fill !== exp_fill()) $display("FAIL first_fill k=%0d got=%0d exp=%0d", k, fill, exp_fill()); else n_pass++;
      n_checks++; if (win_valid !== (k == 4)) $display("FAIL first_win_valid k=%0d got=%b exp=%b", k, win_valid, k == 4); else n_pass++;
    end
    n_checks++; if (win_data !== 32'h9ABC_1234) $display("FAIL first_win_data got=%h exp=9abc1234", win_data); else n_pass++;
    n_checks++; if (dout !== 8'h91) $display("FAIL first_dout got=%h exp=91", dout); else n_pass++;
  endtask

  task automatic test_hop();
    for (int k = 5; k <= 7; k++) begin
      step(1'b1, {4'(8 + k), 4'(k)}, 1'b1, 1'b0);
      n_checks++; if (win_valid !== (k == 6)) $display("FAIL hop_win_valid k=%0d got=%b exp=%b", k, win_valid, k == 6); else n_pass++;
      if (k == 6) begin
        n_checks++; if (win_data !== 32'hBCDE_3456) $display("FAIL hop_win_data got=%h exp=bcde3456", win_data); else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    logic [WD-1:0] snap;
    step(1'b1, 8'h08, 1'b1, 1'b0);
    n_checks++; if (win_valid !== 1'b1) $display("FAIL stall_pre_valid got=%b exp=1", win_valid); else n_pass++;
    snap = exp_win();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 8'h99, 1'b0, 1'b0);
      n_checks++; if (obs_ready !== 1'b0) $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", k, obs_ready); else n_pass++;
      n_checks++; if (win_data !== snap || fill !== FW'(DEPTH) || win_valid !== 1'b1)
        $display("FAIL stall_hold cyc=%0d got=%h/%0d/%b exp=%h/%0d/1", k, win_data, fill, win_valid, snap, DEPTH); else n_pass++;
    end
    step(1'b1, 8'h99, 1'b1, 1'b0);
    n_checks++; if (obs_ready !== 1'b1) $display("FAIL release_in_ready got=%b exp=1", obs_ready); else n_pass++;
    n_checks++; if (win_valid !== 1'b0) $display("FAIL release_win_valid got=%b exp=0", win_valid); else n_pass++;
    n_checks++; if (win_data[3:0] !== 4'h9 || win_data !== exp_win())
      $display("FAIL release_win_data got=%h exp=%h", win_data, exp_win()); else n_pass++;
  endtask

  task automatic test_clear();
    step(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    n_checks++; if (obs_ready !== 1'b0) $display("FAIL clear_in_ready got=%b exp=0", obs_ready); else n_pass++;
    n_checks++; if (fill !== '0 || win_valid !== 1'b0 || win_data !== '0 || dout !== '0)
      $display("FAIL clear_state got fill=%0d wv=%b data=%h dout=%h exp 0", fill, win_valid, win_data, dout); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0);
      n_checks++; if (win_valid !== (k == 4)) $display("FAIL clear_refill k=%0d got=%b exp=%b", k, win_valid, k == 4); else n_pass++;
    end
    n_checks++; if (win_data !== exp_win()) $display("FAIL clear_window got=%h exp=%h", win_data, exp_win()); else n_pass++;
  endtask

  task automatic test_random();
    bit v, r, cl, exp_rdy;
    for (int k = 0; k < 300; k++) begin
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) != 0);
      cl = ($urandom_range(0, 40) == 0);
      exp_rdy = !cl && (!m_wv || r);
      step(v, 8'($urandom), r, cl);
      n_checks++; if (obs_ready !== exp_rdy) $display("FAIL rand_in_ready k=%0d got=%b exp=%b", k, obs_ready, exp_rdy); else n_pass++;
      n_checks++; if (win_valid !== m_wv) $display("FAIL rand_win_valid k=%0d got=%b exp=%b", k, win_valid, m_wv); else n_pass++;
      n_checks++; if (win_data !== exp_win()) $display("FAIL rand_win_data k=%0d got=%h exp=%h", k, win_data, exp_win()); else n_pass++;
      n_checks++; if (fill !== exp_fill()) $display("FAIL rand_fill k=%0d got=%0d exp=%0d", k, fill, exp_fill()); else n_pass++;
      n_checks++; if (dout !== exp_dout()) $display("FAIL rand_dout k=%0d got=%h exp=%h", k, dout, exp_dout()); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [CH*W-1:0] hist [0:15];
    logic [WD-1:0]   e;
    win_ready1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      hist[k]   = 8'($urandom);
      in_valid1 = 1'b1;
      din1      = hist[k];
      #1;
      n_checks++; if (in_ready1 !== 1'b1) $display("FAIL b2b_in_ready k=%0d got=%b exp=1", k, in_ready1); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (win_valid1 !== (k >= DEPTH)) $display("FAIL b2b_win_valid k=%0d got=%b exp=%b", k, win_valid1, k >= DEPTH); else n_pass++;
      if (k >= DEPTH) begin
        e = '0;
        for (int c = 0; c < CH; c++)
          for (int i = 0; i < DEPTH; i++) e[tap_idx(c, i, DEPTH)*W +: W] = hist[k-i][c*W +: W];
        n_checks++; if (win_data1 !== e) $display("FAIL b2b_win_data k=%0d got=%h exp=%h", k, win_data1, e); else n_pass++;
      end
    end
    in_valid1 = 1'b0;
  endtask

  task automatic test_async_reset();
    step(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (fill !== '0 || win_valid !== 1'b0 || win_data !== '0 || dout !== '0)
      $display("FAIL areset_state got fill=%0d wv=%b data=%h dout=%h exp 0", fill, win_valid, win_data, dout); else n_pass++;
    n_checks++; if (win_valid1 !== 1'b0 || win_data1 !== '0 || fill1 !== '0)
      $display("FAIL areset_hop1 got wv=%b data=%h fill=%0d exp 0", win_valid1, win_data1, fill1); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL areset_in_ready got=%b exp=1", in_ready); else n_pass++;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0);
      n_checks++; if (win_valid !== (k == 4)) $display("FAIL areset_refill k=%0d got=%b exp=%b", k, win_valid, k == 4); else n_pass++;
    end
    n_checks++; if (win_data !== exp_win()) $display("FAIL areset_window got=%h exp=%h", win_data, exp_win()); else n_pass++;
  endtask

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    win_ready  = 1'b0;
    din        = '0;
    clear1     = 1'b0;
    in_valid1  = 1'b0;
    win_ready1 = 1'b1;
    din1       = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_first_window();
    test_hop();
    test_stall();
    test_clear();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sliding_window_buffer.md
# sliding_window_buffer

Multi-channel sliding-window sample buffer for the feature-extraction front end: it collects DEPTH samples per channel and then presents a full window every HOP new samples. Input is valid/ready flow-controlled, and the window output uses a valid/ready handshake, so a slow feature unit back-pressures the sensor stream. It generalises the plain fixed shift chain with multiple channels, stall, hop/stride, fill tracking and synchronous flush.

## Interface
- WORD_WIDTH, 4, bits per sample
- DEPTH, 21, window length in samples (≥2)
- CHANNELS, 1, independent parallel channels sharing one handshake (≥1)
- HOP, 1, new samples between successive windows (1..DEPTH)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of contents and counters
- in_valid  in  1  din holds a sample set
- in_ready  out  1  buffer accepts din this cycle
- din  in  CHANNELS*WORD_WIDTH  channel c at [c*WORD_WIDTH +: WORD_WIDTH]
- win_valid  out  1  win_data holds a complete window
- win_ready  in  1  consumer takes the window
- win_data  out  CHANNELS*DEPTH*WORD_WIDTH  tap i of channel c at [(c*DEPTH+i)*WORD_WIDTH +: WORD_WIDTH]; tap 0 = newest
- dout  out  CHANNELS*WORD_WIDTH  tap DEPTH-1 (oldest) of each channel
- fill  out  FILL_W  accepted samples since reset/clear, saturating at DEPTH

## Operation
- accept = in_valid & in_ready; in_ready = !clear & (!win_valid | win_ready), combinational.
- On accept: every channel shifts tap i ← tap i-1, tap 0 ← din slice; no shift otherwise (contents hold).
- fill: +1 per accept while fill < DEPTH, then holds at DEPTH.
- hop_cnt (internal, 0..HOP-1): held at 0 until fill = DEPTH; then +1 per accept.
- Window fire: accept with fill = DEPTH-1 (first window), or accept with fill = DEPTH and hop_cnt = HOP-1; on fire hop_cnt ← 0.
- win_valid: set on fire; cleared on win_valid & win_ready when no fire in the same cycle; fire in the same cycle as the handshake keeps it at 1 (back-to-back windows, HOP=1).
- Accept while win_valid=1 is only possible when win_ready=1, so a presented window never changes before it is taken.
- clear: highest priority after reset; zeros all taps, fill, hop_cnt, win_valid; any sample presented in that cycle is dropped (in_ready=0).
- Arithmetic: FILL_W = $clog2(DEPTH+1); HOP_W = max(1,$clog2(HOP)); counters never wrap.

## Timing
- Reset (async assert, sync release): all taps 0, fill 0, hop_cnt 0, win_valid 0, hence dout 0, win_data 0, in_ready 1.
- Sample accepted at edge k visible at tap 0 after edge k; at dout after DEPTH accepts.
- win_valid rises after the edge of the firing accept: one cycle latency; the window contains the firing sample at tap 0.
- First window after DEPTH accepts; subsequent windows every HOP accepts, independent of idle/stall cycles.
- Reset mid-window: window discarded, no win_valid after release until DEPTH new accepts.

## Structure
- Shared package/header: FILL_W and HOP_W derivation, tap/channel flat-index helper, used by bench and RTL.
- Sub-module window_lane: one channel, DEPTH×WORD_WIDTH taps with shift enable and clear, flat tap output; CHANNELS instances by generate.
- Top holds handshake, fill, hop_cnt, win_valid.

## Test plan
- W=4, DEPTH=4, CHANNELS=2, HOP=2; reset, stream ch0=1,2,3,4 / ch1=9,A,B,C with win_ready=1 → win_valid one cycle after 4th accept; ch0 taps 0..3 = 4,3,2,1, ch1 = C,B,A,9; fill=4.
- Continue stream 5,6,7 → next window only after 6 (taps 6,5,4,3), none after 5 or 7.
- Hold win_ready=0 with in_valid=1 → in_ready=0, win_data and fill stable for 10 cycles; raise win_ready → window taken and next sample accepted in the same cycle.
- HOP=1, win_ready=1, continuous input → win_valid stays 1 every cycle after the first window, each window shifted by one sample.
- Assert clear with in_valid=1 after 3 accepts → in_ready=0, taps/fill/win_valid 0; window needs 4 fresh accepts.
- Async rst_n low mid-stream between edges → outputs 0 immediately; in_ready=1 after release.
